f1_start_controller: RTL and testbench

- Driver-side partner of the CPU top's trigger/output pair: consumes the CPU's a0 light pattern and produces the CPU's T0 trigger.
- Debounces a raw push-button and asserts the trigger to start an F1 light sequence.
- Tracks the sequence through a0, then measures reaction time in clock cycles from lights-out to the next button press.
- Flags false starts: a press before lights-out.

---
 rtl/f1_start_controller.sv | 153 +++++++++++++++
 tb/tb_f1_start_controller.sv | 254 +++++++++++++++++++++++++
 2 files changed

// File: rtl/f1_start_controller.sv
// F1 start-light controller: debounces the driver button, triggers the CPU light
// sequence on t0, follows it through a0[7:0] and measures reaction time or flags a jump start.
`timescale 1ns/1ps
module f1_start_controller #(
    parameter int          WIDTH           = 32,
    parameter int          CNT_WIDTH       = 16,
    parameter int          DEBOUNCE_CYCLES = 4,
    parameter logic [7:0]  LIGHTS_ON       = 8'hFF
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 btn_in,
    input  logic [WIDTH-1:0]     a0,
    output logic                 t0,
    output logic [CNT_WIDTH-1:0] react_cnt,
    output logic                 react_valid,
    output logic                 jump_start,
    output logic                 busy
);

    localparam int DB_W = $clog2(DEBOUNCE_CYCLES + 1);

    typedef enum logic [2:0] {IDLE, ARM, SEQ, FULL, TIMING, DONE} state_t;

    state_t               state, state_next;
    logic                 sync1, sync2, db;
    logic [DB_W-1:0]      db_cnt;
    logic                 db_hit, press;
    logic [7:0]           lights;
    logic                 unused_a0_hi;
    logic [CNT_WIDTH-1:0] counter;
    logic                 cnt_clr, cnt_inc, react_load, jump_set, results_clr;

    assign lights       = a0[7:0];
    assign unused_a0_hi = ^a0[WIDTH-1:8];

    // press fires on the same edge that db flips high, so the FSM sees it with no extra cycle
    assign db_hit = (sync2 != db) && (db_cnt == DB_W'(DEBOUNCE_CYCLES - 1));
    assign press  = db_hit && sync2;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            sync1  <= 1'b0;
            sync2  <= 1'b0;
            db     <= 1'b0;
            db_cnt <= '0;
        end else begin
            sync1 <= btn_in;
            sync2 <= sync1;
            if (sync2 != db) begin
                if (db_hit) begin
                    db     <= sync2;
                    db_cnt <= '0;
                end else begin
                    db_cnt <= db_cnt + DB_W'(1);
                end
            end else begin
                db_cnt <= '0;
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // A press always takes priority over a0 so a press coinciding with lights-out is a jump start
    always_comb begin
        state_next  = state;
        cnt_clr     = 1'b0;
        cnt_inc     = 1'b0;
        react_load  = 1'b0;
        jump_set    = 1'b0;
        results_clr = 1'b0;
        case (state)
            IDLE: begin
                if (press) state_next = ARM;
            end
            ARM: begin
                if (lights != 8'h00) state_next = SEQ;
            end
            SEQ: begin
                if (press) begin
                    state_next = DONE;
                    jump_set   = 1'b1;
                end else if (lights == LIGHTS_ON) begin
                    state_next = FULL;
                end else if (lights == 8'h00) begin
                    state_next = IDLE;
                end
            end
            FULL: begin
                if (press) begin
                    state_next = DONE;
                    jump_set   = 1'b1;
                end else if (lights == 8'h00) begin
                    state_next = TIMING;
                    cnt_clr    = 1'b1;
                end
            end
            TIMING: begin
                if (press) begin
                    state_next = DONE;
                    react_load = 1'b1;
                end else begin
                    cnt_inc = 1'b1;
                end
            end
            DONE: begin
                if (press) begin
                    state_next  = ARM;
                    results_clr = 1'b1;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            t0          <= 1'b0;
            counter     <= '0;
            react_cnt   <= '0;
            react_valid <= 1'b0;
            jump_start  <= 1'b0;
        end else begin
            t0 <= (state_next == ARM);
            if (cnt_clr) begin
                counter <= '0;
            end else if (cnt_inc && (counter != {CNT_WIDTH{1'b1}})) begin
                counter <= counter + CNT_WIDTH'(1);
            end
            if (react_load) begin
                react_cnt   <= counter;
                react_valid <= 1'b1;
            end
            if (jump_set) begin
                jump_start <= 1'b1;
            end
            if (results_clr) begin
                react_valid <= 1'b0;
                jump_start  <= 1'b0;
            end
        end
    end

    assign busy = (state == ARM) || (state == SEQ) || (state == FULL) || (state == TIMING);

endmodule

// File: tb/tb_f1_start_controller.sv
// Self-checking bench for f1_start_controller: table-driven light sequence plus
// hand-written debounce, timing, false-start, saturation and reset sequences.
`timescale 1ns/1ps
module tb_f1_start_controller;

    localparam int WIDTH     = 32;
    localparam int CNT_WIDTH = 8;

    logic                 clk = 1'b0;
    logic                 rst;
    logic                 btn_in;
    logic [WIDTH-1:0]     a0;
    logic                 t0;
    logic [CNT_WIDTH-1:0] react_cnt;
    logic                 react_valid;
    logic                 jump_start;
    logic                 busy;

    int n_compared   = 0;
    int n_mismatched = 0;

    typedef struct {
        int   cnt;
        logic valid;
        logic jump;
    } result_t;

    typedef struct {
        logic             btn;
        logic [WIDTH-1:0] a0;
        int               hold;
        logic             exp_t0;
        logic             exp_busy;
        logic             exp_valid;
        logic             exp_jump;
    } vec_t;

    result_t expected_q[$];
    logic    prev_flag = 1'b0;

    f1_start_controller #(
        .WIDTH(WIDTH),
        .CNT_WIDTH(CNT_WIDTH),
        .DEBOUNCE_CYCLES(4),
        .LIGHTS_ON(8'hFF)
    ) dut (
        .clk(clk),
        .rst(rst),
        .btn_in(btn_in),
        .a0(a0),
        .t0(t0),
        .react_cnt(react_cnt),
        .react_valid(react_valid),
        .jump_start(jump_start),
        .busy(busy)
    );

    always #5 clk = ~clk;

    task automatic check_output(input string name, input logic [31:0] actual, input logic [31:0] expected);
        n_compared++;
        if (actual !== expected) begin
            n_mismatched++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, actual, expected);
        end
    endtask

    task automatic check_flags(input string name, input logic e_t0, input logic e_busy,
                               input logic e_valid, input logic e_jump);
        check_output({name, ".t0"}, 32'(t0), 32'(e_t0));
        check_output({name, ".busy"}, 32'(busy), 32'(e_busy));
        check_output({name, ".react_valid"}, 32'(react_valid), 32'(e_valid));
        check_output({name, ".jump_start"}, 32'(jump_start), 32'(e_jump));
    endtask

    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic press_release();
        btn_in = 1'b1;
        step(10);
        btn_in = 1'b0;
        step(8);
    endtask

    task automatic apply_stimulus(input vec_t v);
        btn_in = v.btn;
        a0     = v.a0;
        step(v.hold);
    endtask

    // Scoreboard: each completed run (valid or jump start) is matched against the oldest prediction
    always @(negedge clk) begin
        if (!rst) begin
            prev_flag = 1'b0;
        end else begin
            if ((react_valid || jump_start) && !prev_flag) begin
                if (expected_q.size() == 0) begin
                    check_output("sb.unexpected_result", 32'(react_valid || jump_start), 32'd0);
                end else begin
                    result_t r;
                    r = expected_q.pop_front();
                    check_output("sb.react_cnt", 32'(react_cnt), 32'(r.cnt));
                    check_output("sb.react_valid", 32'(react_valid), 32'(r.valid));
                    check_output("sb.jump_start", 32'(jump_start), 32'(r.jump));
                end
            end
            prev_flag = react_valid || jump_start;
        end
    end

    initial begin
        vec_t vecs[$];
        vecs.push_back('{1'b1, 32'h0000_0000, 10, 1'b1, 1'b1, 1'b0, 1'b0});
        vecs.push_back('{1'b0, 32'h0000_0000,  8, 1'b1, 1'b1, 1'b0, 1'b0});
        vecs.push_back('{1'b0, 32'hFFFF_FF00,  3, 1'b1, 1'b1, 1'b0, 1'b0});
        vecs.push_back('{1'b0, 32'h0000_0001,  1, 1'b0, 1'b1, 1'b0, 1'b0});
        vecs.push_back('{1'b0, 32'h0000_0003,  1, 1'b0, 1'b1, 1'b0, 1'b0});
        vecs.push_back('{1'b0, 32'h0000_0007,  1, 1'b0, 1'b1, 1'b0, 1'b0});
        vecs.push_back('{1'b0, 32'h0000_000F,  1, 1'b0, 1'b1, 1'b0, 1'b0});
        vecs.push_back('{1'b0, 32'h0000_001F,  1, 1'b0, 1'b1, 1'b0, 1'b0});
        vecs.push_back('{1'b0, 32'h0000_003F,  1, 1'b0, 1'b1, 1'b0, 1'b0});
        vecs.push_back('{1'b0, 32'h0000_007F,  1, 1'b0, 1'b1, 1'b0, 1'b0});
        vecs.push_back('{1'b0, 32'h0000_00FF,  2, 1'b0, 1'b1, 1'b0, 1'b0});
        vecs.push_back('{1'b0, 32'h1234_56FF,  3, 1'b0, 1'b1, 1'b0, 1'b0});

        rst    = 1'b0;
        btn_in = 1'b0;
        a0     = '0;
        #1;
        check_flags("reset", 1'b0, 1'b0, 1'b0, 1'b0);
        check_output("reset.react_cnt", 32'(react_cnt), 32'd0);
        @(negedge clk);
        rst = 1'b1;
        @(posedge clk);
        #1;

        for (int i = 0; i < 20; i++) begin
            step(1);
            check_flags("idle", 1'b0, 1'b0, 1'b0, 1'b0);
        end

        btn_in = 1'b1;
        step(3);
        btn_in = 1'b0;
        step(12);
        check_flags("glitch", 1'b0, 1'b0, 1'b0, 1'b0);

        btn_in = 1'b1;
        for (int k = 1; k <= 6; k++) begin
            step(1);
            check_output($sformatf("debounce_latency.edge%0d", k), 32'(t0), 32'(k == 6));
        end
        step(4);
        btn_in = 1'b0;
        step(8);
        check_flags("armed", 1'b1, 1'b1, 1'b0, 1'b0);

        foreach (vecs[i]) begin
            apply_stimulus(vecs[i]);
            check_flags($sformatf("vec%0d", i), vecs[i].exp_t0, vecs[i].exp_busy,
                        vecs[i].exp_valid, vecs[i].exp_jump);
        end

        // Lights out, then a press consumed when 100 cycles have been counted
        a0 = '0;
        step(1);
        step(95);
        check_flags("timing", 1'b0, 1'b1, 1'b0, 1'b0);
        btn_in = 1'b1;
        expected_q.push_back('{100, 1'b1, 1'b0});
        step(6);
        check_flags("reaction", 1'b0, 1'b0, 1'b1, 1'b0);
        check_output("reaction.react_cnt", 32'(react_cnt), 32'd100);
        step(4);
        btn_in = 1'b0;
        step(8);

        press_release();
        check_flags("rearm", 1'b1, 1'b1, 1'b0, 1'b0);
        a0 = 32'h1;
        step(1);
        a0 = 32'h0F;
        step(2);
        expected_q.push_back('{100, 1'b0, 1'b1});
        press_release();
        check_flags("false_start_seq", 1'b0, 1'b0, 1'b0, 1'b1);
        a0 = '0;
        press_release();
        check_flags("after_false_start", 1'b1, 1'b1, 1'b0, 1'b0);

        a0 = 32'hFF;
        step(2);
        check_flags("full", 1'b0, 1'b1, 1'b0, 1'b0);
        btn_in = 1'b1;
        step(5);
        a0 = '0;
        expected_q.push_back('{100, 1'b0, 1'b1});
        step(1);
        check_flags("press_vs_lights_out", 1'b0, 1'b0, 1'b0, 1'b1);
        step(4);
        btn_in = 1'b0;
        step(8);

        press_release();
        a0 = 32'h1;
        step(1);
        a0 = '0;
        step(1);
        check_flags("abort", 1'b0, 1'b0, 1'b0, 1'b0);

        press_release();
        a0 = 32'h1;
        step(1);
        a0 = 32'hFF;
        step(1);
        a0 = '0;
        step(1);
        step(300);
        expected_q.push_back('{255, 1'b1, 1'b0});
        press_release();
        check_output("saturation.react_cnt", 32'(react_cnt), 32'd255);

        press_release();
        a0 = 32'h1;
        step(1);
        a0 = 32'hFF;
        step(1);
        a0 = '0;
        step(21);
        check_flags("pre_reset", 1'b0, 1'b1, 1'b0, 1'b0);
        #2;
        rst    = 1'b0;
        btn_in = 1'b1;
        #1;
        check_flags("async_reset", 1'b0, 1'b0, 1'b0, 1'b0);
        check_output("async_reset.react_cnt", 32'(react_cnt), 32'd0);
        @(negedge clk);
        rst = 1'b1;
        for (int k = 1; k <= 6; k++) begin
            step(1);
            check_output($sformatf("post_reset_press.edge%0d", k), 32'(t0), 32'(k == 6));
        end
        btn_in = 1'b0;
        step(10);

        check_output("sb.pending", 32'(expected_q.size()), 32'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_compared, n_mismatched);
        $finish;
    end

endmodule
